chan_mux_rr: RTL

- Parametrised N-channel, W-bit registered channel multiplexer with valid/ready handshake on every input and on the output.
- Two modes:
  - Direct-select: channel chosen by `sel`.
  - Round-robin: fair arbitration among valid channels.
- Sits between producer units (ALU result lanes, operand sources) and a single downstream consumer.
- Replaces the fixed-width single-bit combinational muxes with a buffered, back-pressure-aware stage.

---
 rtl/chan_mux_rr_pkg.sv | 17 +
 rtl/chan_mux_rr_rr_pick.sv | 30 +++
 rtl/chan_mux_rr.sv | 115 +++++++++++
 3 files changed

// File: rtl/chan_mux_rr_pkg.sv
// Shared constants for the registered round-robin channel mux.
// Mode encodings and the select-width rule.
package chan_mux_rr_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Minimum select width able to index nch channels: ceil(log2(nch)),
    // with a floor of 1 so a two-channel mux still has a select bit.
    function automatic int sel_width(input int nch);
        int w;
        w = 1;
        while ((1 << w) < nch) w++;
        return w;
    endfunction

endpackage

// File: rtl/chan_mux_rr_rr_pick.sv
// Rotated priority encoder: first set request at or after ptr,
// wrapping modulo NCH.
module rr_pick
    import chan_mux_rr_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int SELW = 3
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            grant_valid,
    output logic [SELW-1:0] grant_idx
);

    // Scan offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        int j;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NCH) j = j - NCH;
            if (req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = SELW'(j);
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered mux with valid/ready on every port.
// Direct-select or round-robin grant into a single output register.
module chan_mux_rr
    import chan_mux_rr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    if (SELW < sel_width(NCH)) begin : g_bad_selw
        $error("chan_mux_rr: SELW too small for NCH");
    end

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;
    logic             r_out_valid;
    logic [SELW-1:0]  r_rr_ptr;

    logic             w_load_en;
    logic             w_sel_valid;
    logic             w_rr_valid;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_grant_valid;
    logic [SELW-1:0]  w_grant_idx;
    logic [WIDTH-1:0] w_grant_data;
    logic             w_xfer;
    logic [SELW-1:0]  w_ptr_next;

    assign w_load_en = !r_out_valid | out_ready;

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_pick (
        .req         (in_valid),
        .ptr         (r_rr_ptr),
        .grant_valid (w_rr_valid),
        .grant_idx   (w_rr_idx)
    );

    // Direct-select validity; a sel beyond the last channel never matches.
    always_comb begin
        w_sel_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i)) w_sel_valid = in_valid[i];
        end
    end

    assign w_grant_valid = (mode == MODE_RR) ? w_rr_valid : w_sel_valid;
    assign w_grant_idx   = (mode == MODE_RR) ? w_rr_idx   : sel;
    assign w_xfer        = w_load_en & w_grant_valid;

    // One-hot ready toward the granted producer, muted during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = w_xfer & !reset & (w_grant_idx == SELW'(i));
        end
    end

    // Data of the granted channel, feeding only the output register.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant_idx == SELW'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_grant_idx == SELW'(NCH - 1)) ?
                        '0 : w_grant_idx + 1'b1;

    // Output stage: load on transfer, clear valid on a bare drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_chan  <= w_grant_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner of each RR transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_xfer && mode == MODE_RR) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule
